// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared pc_gen control codes and sequencer state encodings
package pc_seq_pkg;

   // Control codes seen by pc_gen
   localparam logic [3:0] PC_IGN = 4'd0;
   localparam logic [3:0] PC_KEP = 4'd1;
   localparam logic [3:0] PC_IRQ = 4'd2;
   localparam logic [3:0] PC_RST = 4'd3;

   // Sequencer states
   typedef enum logic [2:0] {
      SEQ_RST       = 3'd0,
      SEQ_RUN       = 3'd1,
      SEQ_STALL     = 3'd2,
      SEQ_IRQ_WAIT  = 3'd3,
      SEQ_IRQ_ENTER = 3'd4
   } seq_state_t;

endpackage

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - front-end sequencer driving pc_gen, reg_array freeze, flush and interrupt entry
module pc_seq
   import pc_seq_pkg::*;
#(
   parameter int RST_CYCLES = 2
)(
   input  logic        clock,
   input  logic        rst_n,
   input  logic        stall_req,
   input  logic        irq_req,
   input  logic        irq_en,
   input  logic        br_in_flight,
   input  logic        ret_i,
   input  logic [31:0] pc,
   output logic [3:0]  pc_prectl,
   output logic        rd_clk_cls,
   output logic        flush,
   output logic        irq_ack,
   output logic [31:0] zz_spc,
   output logic        in_isr
);

   localparam logic [3:0] RST_LOAD = 4'(RST_CYCLES - 1);

   seq_state_t  r_state;
   seq_state_t  w_state_nxt;
   logic [3:0]  r_rst_cnt;
   logic [31:0] r_spc;
   logic        r_in_isr;
   logic        w_take;
   logic        w_irq_live;
   logic [3:0]  w_prectl;
   logic        w_cls;
   logic        w_flush;
   logic        w_ack;

   // The old in_isr masks the request, so a return and a new request in the
   // same cycle delay entry by one cycle.
   assign w_take     = irq_req & irq_en & ~r_in_isr;
   assign w_irq_live = irq_req & irq_en;

   // State register and post-reset hold counter
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= SEQ_RST;
         r_rst_cnt <= RST_LOAD;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == SEQ_RST && r_rst_cnt != 4'd0)
            r_rst_cnt <= r_rst_cnt - 4'd1;
      end
   end

   // Saved return PC and handler-active flag; the save happens on the edge leaving IRQ_ENTER
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_spc    <= 32'd0;
         r_in_isr <= 1'b0;
      end else if (r_state == SEQ_IRQ_ENTER) begin
         r_spc    <= pc;
         r_in_isr <= 1'b1;
      end else if (r_state != SEQ_RST && ret_i) begin
         r_in_isr <= 1'b0;
      end
   end

   // Next-state selection
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         SEQ_RST: begin
            if (r_rst_cnt == 4'd0)
               w_state_nxt = SEQ_RUN;
         end
         SEQ_RUN: begin
            if (stall_req)
               w_state_nxt = SEQ_STALL;
            else if (w_take && br_in_flight)
               w_state_nxt = SEQ_IRQ_WAIT;
            else if (w_take)
               w_state_nxt = SEQ_IRQ_ENTER;
         end
         SEQ_STALL: begin
            if (!stall_req)
               w_state_nxt = SEQ_RUN;
         end
         SEQ_IRQ_WAIT: begin
            // A stall keeps the request pending as a level; a dropped request is abandoned
            if (stall_req)
               w_state_nxt = SEQ_STALL;
            else if (!w_irq_live)
               w_state_nxt = SEQ_RUN;
            else if (!br_in_flight)
               w_state_nxt = SEQ_IRQ_ENTER;
         end
         SEQ_IRQ_ENTER: begin
            w_state_nxt = SEQ_RUN;
         end
         default: begin
            w_state_nxt = SEQ_RST;
         end
      endcase
   end

   // Moore output decode from state only
   always_comb begin
      w_prectl = PC_IGN;
      w_cls    = 1'b0;
      w_flush  = 1'b0;
      w_ack    = 1'b0;
      case (r_state)
         SEQ_RST: begin
            w_prectl = PC_RST;
            w_cls    = 1'b1;
            w_flush  = 1'b1;
         end
         SEQ_STALL, SEQ_IRQ_WAIT: begin
            w_prectl = PC_KEP;
            w_cls    = 1'b1;
         end
         SEQ_IRQ_ENTER: begin
            w_prectl = PC_IRQ;
            w_flush  = 1'b1;
            w_ack    = 1'b1;
         end
         default: begin
            w_prectl = PC_IGN;
         end
      endcase
   end

   assign pc_prectl  = w_prectl;
   assign rd_clk_cls = w_cls;
   assign flush      = w_flush;
   assign irq_ack    = w_ack;
   assign zz_spc     = r_spc;
   assign in_isr     = r_in_isr;

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - scoreboard bench for pc_seq with directed vectors
module tb_pc_seq;
   import pc_seq_pkg::*;

   typedef struct packed {
      logic [3:0]  prectl;
      logic        cls;
      logic        fl;
      logic        ack;
      logic [31:0] spc;
      logic        isr;
   } exp_t;

   logic        clock;
   logic        rst_n;
   logic        stall_req;
   logic        irq_req;
   logic        irq_en;
   logic        br_in_flight;
   logic        ret_i;
   logic [31:0] pc;
   logic [3:0]  pc_prectl;
   logic        rd_clk_cls;
   logic        flush;
   logic        irq_ack;
   logic [31:0] zz_spc;
   logic        in_isr;

   int errors = 0;
   int checks = 0;

   exp_t  exp_q[$];
   string name_q[$];

   pc_seq #(.RST_CYCLES(2)) dut (
      .clock        (clock),
      .rst_n        (rst_n),
      .stall_req    (stall_req),
      .irq_req      (irq_req),
      .irq_en       (irq_en),
      .br_in_flight (br_in_flight),
      .ret_i        (ret_i),
      .pc           (pc),
      .pc_prectl    (pc_prectl),
      .rd_clk_cls   (rd_clk_cls),
      .flush        (flush),
      .irq_ack      (irq_ack),
      .zz_spc       (zz_spc),
      .in_isr       (in_isr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic exp_t dut_out();
      exp_t o;
      o.prectl = pc_prectl;
      o.cls    = rd_clk_cls;
      o.fl     = flush;
      o.ack    = irq_ack;
      o.spc    = zz_spc;
      o.isr    = in_isr;
      return o;
   endfunction

   task automatic compare(input string nm, input exp_t act, input exp_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got prectl=%0d cls=%b flush=%b ack=%b spc=%h isr=%b, want prectl=%0d cls=%b flush=%b ack=%b spc=%h isr=%b",
                  nm, act.prectl, act.cls, act.fl, act.ack, act.spc, act.isr,
                  exp.prectl, exp.cls, exp.fl, exp.ack, exp.spc, exp.isr);
      end
   endtask

   // Monitor: one expected response per cycle, compared mid-cycle
   initial begin
      exp_t  e;
      string n;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            compare(n, dut_out(), e);
         end
      end
   end

   // Apply inputs for the next rising edge and queue the outputs expected after it
   task automatic step(input string nm,
                       input logic rn, input logic st, input logic ir, input logic en,
                       input logic br, input logic rt, input logic [31:0] p,
                       input logic [3:0] e_pc, input logic e_cls, input logic e_fl,
                       input logic e_ack, input logic [31:0] e_spc, input logic e_isr);
      exp_t e;
      logic fell;
      @(negedge clock);
      #1;
      fell         = rst_n & ~rn;
      rst_n        = rn;
      stall_req    = st;
      irq_req      = ir;
      irq_en       = en;
      br_in_flight = br;
      ret_i        = rt;
      pc           = p;
      e.prectl = e_pc;
      e.cls    = e_cls;
      e.fl     = e_fl;
      e.ack    = e_ack;
      e.spc    = e_spc;
      e.isr    = e_isr;
      exp_q.push_back(e);
      name_q.push_back(nm);
      if (fell) begin
         exp_t r;
         #1;
         r.prectl = PC_RST; r.cls = 1'b1; r.fl = 1'b1; r.ack = 1'b0; r.spc = 32'd0; r.isr = 1'b0;
         compare({nm, "_async"}, dut_out(), r);
      end
   endtask

   initial begin
      rst_n = 1'b0; stall_req = 1'b0; irq_req = 1'b0; irq_en = 1'b0;
      br_in_flight = 1'b0; ret_i = 1'b0; pc = 32'd0;

      //    name              rn st ir en br rt pc             prectl  cls fl ack spc            isr
      step("reset",          0, 0, 0, 0, 0, 0, 32'h0,       PC_RST, 1, 1, 0, 32'h0,       0);
      step("rst_c1",         1, 0, 0, 0, 0, 0, 32'h0,       PC_RST, 1, 1, 0, 32'h0,       0);
      step("rst_done",       1, 0, 0, 0, 0, 0, 32'h0,       PC_IGN, 0, 0, 0, 32'h0,       0);
      step("idle",           1, 0, 0, 0, 0, 0, 32'h0,       PC_IGN, 0, 0, 0, 32'h0,       0);
      step("stall1",         1, 1, 0, 0, 0, 0, 32'h0,       PC_KEP, 1, 0, 0, 32'h0,       0);
      step("stall2",         1, 1, 0, 0, 0, 0, 32'h0,       PC_KEP, 1, 0, 0, 32'h0,       0);
      step("stall3",         1, 1, 0, 0, 0, 0, 32'h0,       PC_KEP, 1, 0, 0, 32'h0,       0);
      step("stall_end",      1, 0, 0, 0, 0, 0, 32'h0,       PC_IGN, 0, 0, 0, 32'h0,       0);
      step("irq_enter",      1, 0, 1, 1, 0, 0, 32'h100,     PC_IRQ, 0, 1, 1, 32'h0,       0);
      step("irq_save",       1, 0, 0, 1, 0, 0, 32'h100,     PC_IGN, 0, 0, 0, 32'h100,     1);
      step("irq_masked",     1, 0, 1, 1, 0, 0, 32'h100,     PC_IGN, 0, 0, 0, 32'h100,     1);
      step("ret_same",       1, 0, 1, 1, 0, 1, 32'h200,     PC_IGN, 0, 0, 0, 32'h100,     0);
      step("irq_after_ret",  1, 0, 1, 1, 0, 0, 32'h200,     PC_IRQ, 0, 1, 1, 32'h100,     0);
      step("save2",          1, 0, 0, 1, 0, 0, 32'h200,     PC_IGN, 0, 0, 0, 32'h200,     1);
      step("ret_keep",       1, 0, 0, 1, 0, 1, 32'h200,     PC_IGN, 0, 0, 0, 32'h200,     0);
      step("br_wait1",       1, 0, 1, 1, 1, 0, 32'h300,     PC_KEP, 1, 0, 0, 32'h200,     0);
      step("br_wait2",       1, 0, 1, 1, 1, 0, 32'h300,     PC_KEP, 1, 0, 0, 32'h200,     0);
      step("br_enter",       1, 0, 1, 1, 0, 0, 32'h300,     PC_IRQ, 0, 1, 1, 32'h200,     0);
      step("br_save",        1, 0, 0, 1, 0, 0, 32'h300,     PC_IGN, 0, 0, 0, 32'h300,     1);
      step("ret3",           1, 0, 0, 1, 0, 1, 32'h300,     PC_IGN, 0, 0, 0, 32'h300,     0);
      step("abandon_wait",   1, 0, 1, 1, 1, 0, 32'h300,     PC_KEP, 1, 0, 0, 32'h300,     0);
      step("abandon",        1, 0, 0, 1, 1, 0, 32'h300,     PC_IGN, 0, 0, 0, 32'h300,     0);
      step("wst_wait",       1, 0, 1, 1, 1, 0, 32'h300,     PC_KEP, 1, 0, 0, 32'h300,     0);
      step("wst_stall",      1, 1, 1, 1, 1, 0, 32'h300,     PC_KEP, 1, 0, 0, 32'h300,     0);
      step("wst_run",        1, 0, 1, 1, 0, 0, 32'h300,     PC_IGN, 0, 0, 0, 32'h300,     0);
      step("wst_enter",      1, 0, 1, 1, 0, 0, 32'h400,     PC_IRQ, 0, 1, 1, 32'h300,     0);
      step("wst_save",       1, 0, 0, 1, 0, 0, 32'h400,     PC_IGN, 0, 0, 0, 32'h400,     1);
      step("ret4",           1, 0, 0, 1, 0, 1, 32'h400,     PC_IGN, 0, 0, 0, 32'h400,     0);
      step("en_off",         1, 0, 1, 0, 0, 0, 32'h400,     PC_IGN, 0, 0, 0, 32'h400,     0);
      step("stall_prio",     1, 1, 1, 1, 0, 0, 32'h400,     PC_KEP, 1, 0, 0, 32'h400,     0);
      step("stall_prio_end", 1, 0, 0, 1, 0, 0, 32'h400,     PC_IGN, 0, 0, 0, 32'h400,     0);
      step("rst_wait",       1, 0, 1, 1, 1, 0, 32'h400,     PC_KEP, 1, 0, 0, 32'h400,     0);
      step("mid_reset",      0, 0, 1, 1, 1, 0, 32'h400,     PC_RST, 1, 1, 0, 32'h0,       0);
      step("rst2_c1",        1, 0, 0, 0, 0, 0, 32'h0,       PC_RST, 1, 1, 0, 32'h0,       0);
      step("rst2_done",      1, 0, 0, 0, 0, 0, 32'h0,       PC_IGN, 0, 0, 0, 32'h0,       0);
      step("idle2",          1, 0, 0, 0, 0, 0, 32'h0,       PC_IGN, 0, 0, 0, 32'h0,       0);

      // Let the monitor drain, bounded
      for (int i = 0; i < 10 && exp_q.size() > 0; i++)
         @(negedge clock);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
